zeroriscy_trace_ctrl: RTL and testbench
=======================================

ZEROR ISCY_TRACE_CTRL -- requirements
Module: zeroriscy_trace_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of trace records held on chip (power of 2, >=2).
REQ-002 Parameter BUF_RECORDS, default 256: number of 16-byte record slots in the memory ring (power of 2).
REQ-003 clk  input  1  core clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 trace_en_i  input  1  capture enable, level.
REQ-006 retire_valid_i  input  1  one instruction retires this cycle.
REQ-007 retire_pc_i  input  32  PC of retiring instruction.
REQ-008 retire_instr_i  input  32  instruction word.
REQ-009 retire_wdata_i  input  32  register write-back value (0 if none).
REQ-010 buf_base_i  input  32  ring base byte address; bits [3:0] ignored.
REQ-011 data_req_o  output  1  memory write request.
REQ-012 data_gnt_i  input  1  request accepted.
REQ-013 data_rvalid_i  input  1  write response.
REQ-014 data_we_o  output  1  write enable.
REQ-015 data_be_o  output  4  byte enables.
REQ-016 data_addr_o  output  32  word address.
REQ-017 data_wdata_o  output  32  write data.
REQ-018 busy_o  output  1  FIFO non-empty or drain FSM not IDLE.
REQ-019 overflow_cnt_o  output  16  dropped-record count.
REQ-020 slot_o  output  log2(BUF_RECORDS)  next ring slot to be written.

Function
REQ-021 Free-running 32-bit cycle counter SHALL count from 0 after reset, +1 per clock, wrapping at 2^32.
REQ-022 Record = {cycle, pc, instr, wdata} sampled in the cycle retire_valid_i && trace_en_i is high.
REQ-023 Push accepted iff registered FIFO count != FIFO_DEPTH; no push-through on a same-cycle pop at full.
REQ-024 Rejected push (full) SHALL increment overflow_cnt_o, saturating at 0xFFFF; record discarded.
REQ-025 Same-cycle push and pop with count in 1..FIFO_DEPTH-1: count unchanged, FIFO order preserved.
REQ-026 Drain FSM states: IDLE, REQ, WAIT.
REQ-027 IDLE -> REQ when FIFO non-empty; word index k=0.
REQ-028 REQ: data_req_o=1, held with stable addr/wdata until data_gnt_i; on gnt -> WAIT.
REQ-029 WAIT: data_req_o=0; on data_rvalid_i: if k<3 then k+1, -> REQ; if k==3 pop head, slot+1, -> REQ if FIFO still non-empty else IDLE.
REQ-030 data_rvalid_i outside WAIT SHALL be ignored.
REQ-031 data_addr_o = {buf_base_i[31:4],4'b0} + slot*16 + k*4, 32-bit modulo.
REQ-032 Word order k=0..3: cycle, pc, instr, wdata.
REQ-033 data_we_o = data_req_o; data_be_o = {4{data_req_o}}; data_addr_o and data_wdata_o = 0 when data_req_o=0.
REQ-034 slot wraps BUF_RECORDS-1 -> 0; no stop on wrap (ring overwrite).
REQ-035 Deasserting trace_en_i stops pushes only; queued and in-flight records complete.
REQ-036 Minimum latency retire -> first data_req_o: 2 cycles (push edge, IDLE->REQ edge).
REQ-037 busy_o SHALL be combinational from FIFO count and FSM state.

Reset
REQ-038 On rst_n=0 immediately: FSM IDLE, k=0, FIFO empty, slot 0, cycle counter 0, overflow 0; all outputs 0.
REQ-039 Reset mid-transaction SHALL abandon the record; a late rvalid after reset release is ignored (FSM IDLE).

Verification
REQ-040 Single record: base 0x1000, retire pc 0x80, instr 0x00100093, wdata 1, gnt/rvalid 1-cycle -> writes 0x1000..0x100C in order cycle,0x80,0x00100093,1; slot_o=1; busy_o low after.
REQ-041 Back-pressure: gnt held low 5 cycles on k=1 -> data_req_o, addr 0x1004, wdata stable all 5 cycles; no duplicate write.
REQ-042 Overflow: FIFO_DEPTH=4, gnt tied 0, 6 consecutive retires -> 4 queued, overflow_cnt_o=2; releasing gnt drains exactly 4 records in order.
REQ-043 Wrap: BUF_RECORDS=4, 5 records from base 0x2000 -> 5th record at 0x2000, slot_o=1.
REQ-044 Enable: trace_en_i low with retire_valid_i high 10 cycles -> no push, busy_o=0, overflow 0; deassert while 2 queued -> both still drained.
REQ-045 Async reset asserted in WAIT with k=2 -> outputs 0 same cycle; after release, stray rvalid produces no state change, slot_o=0.

Source files
------------

// File: rtl/zeroriscy_trace_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : zeroriscy_trace_ctrl_if
// Description : Memory write port used by the trace controller to push
//               trace records into the memory ring.
// Revision    : 1.0 - initial release
// ============================================================================
interface zeroriscy_trace_ctrl_if;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;

    // Trace controller side: issues write requests.
    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i
    );

    // Memory side: accepts requests and returns write responses.
    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i
    );
endinterface
`default_nettype wire

// File: rtl/zeroriscy_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : zeroriscy_trace_ctrl
// Description : Captures retired-instruction trace records into a small FIFO
//               and drains them, one 32-bit word at a time, into a ring of
//               16-byte slots in memory.
// Revision    : 1.0 - initial release
// ============================================================================
module zeroriscy_trace_ctrl #(
    parameter  int FIFO_DEPTH  = 4,
    parameter  int BUF_RECORDS = 256,
    localparam int c_SLOT_W    = $clog2(BUF_RECORDS)
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    trace_en_i,
    input  wire                    retire_valid_i,
    input  wire [31:0]             retire_pc_i,
    input  wire [31:0]             retire_instr_i,
    input  wire [31:0]             retire_wdata_i,
    input  wire [31:0]             buf_base_i,
    zeroriscy_trace_ctrl_if.master bus,
    output logic                   busy_o,
    output logic [15:0]            overflow_cnt_o,
    output logic [c_SLOT_W-1:0]    slot_o
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0] c_CNT_FULL = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0] c_CNT_ONE  = (c_AW+1)'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          r_k;
    logic [c_SLOT_W-1:0] r_slot;
    logic [31:0]         r_cycle;
    logic [15:0]         r_ovf;
    logic [c_AW:0]       r_count;
    logic [c_AW-1:0]     r_wptr;
    logic [c_AW-1:0]     r_rptr;
    logic [127:0]        r_mem [FIFO_DEPTH];

    logic         w_push_try;
    logic         w_full;
    logic         w_push;
    logic         w_pop;
    logic         w_req;
    logic [127:0] w_head;
    logic [31:0]  w_word;
    logic [31:0]  w_addr;

    assign w_push_try = retire_valid_i && trace_en_i;
    // Fullness uses the registered count, so a pop in the same cycle never frees room.
    assign w_full     = (r_count == c_CNT_FULL);
    assign w_push     = w_push_try && !w_full;
    assign w_pop      = (r_state == c_WAIT) && bus.data_rvalid_i && (r_k == 2'd3);
    assign w_req      = (r_state == c_REQ);
    assign w_head     = r_mem[r_rptr];

    // Select the head-record word for the current index: cycle, pc, instr, wdata.
    always_comb begin
        w_word = w_head[31:0];
        case (r_k)
            2'd1:    w_word = w_head[63:32];
            2'd2:    w_word = w_head[95:64];
            2'd3:    w_word = w_head[127:96];
            default: w_word = w_head[31:0];
        endcase
    end

    assign w_addr = (buf_base_i & 32'hFFFF_FFF0)
                  + {{(28-c_SLOT_W){1'b0}}, r_slot, 4'b0000}
                  + {28'd0, r_k, 2'b00};

    assign bus.data_req_o   = w_req;
    assign bus.data_we_o    = w_req;
    assign bus.data_be_o    = {4{w_req}};
    assign bus.data_addr_o  = w_req ? w_addr : 32'd0;
    assign bus.data_wdata_o = w_req ? w_word : 32'd0;

    assign busy_o         = (r_count != '0) || (r_state != c_IDLE);
    assign overflow_cnt_o = r_ovf;
    assign slot_o         = r_slot;

    // Free-running cycle counter stamped into each record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cycle <= 32'd0;
        else        r_cycle <= r_cycle + 32'd1;
    end

    // Record storage; contents are only observed while a request is active.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {retire_wdata_i, retire_instr_i, retire_pc_i, r_cycle};
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 16'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push_try && w_full && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
        end
    end

    // Drain FSM: one request per word, each waiting for its write response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_k     <= 2'd0;
            r_slot  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_k <= 2'd0;
                    if (r_count != '0) r_state <= c_REQ;
                end
                c_REQ: begin
                    if (bus.data_gnt_i) r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (bus.data_rvalid_i) begin
                        if (r_k != 2'd3) begin
                            r_k     <= r_k + 2'd1;
                            r_state <= c_REQ;
                        end else begin
                            r_k     <= 2'd0;
                            r_slot  <= r_slot + c_SLOT_W'(1);
                            // Another record remains if more than one was queued or one arrives now.
                            r_state <= ((r_count > c_CNT_ONE) || w_push) ? c_REQ : c_IDLE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_zeroriscy_trace_ctrl
// Description : Directed and randomized bench for zeroriscy_trace_ctrl with a
//               queue-based record model and a reactive memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zeroriscy_trace_ctrl;
    localparam int DEPTH = 4;
    localparam int BUFR  = 4;

    typedef logic [3:0][31:0] rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] instr = 32'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] base = 32'd0;
    logic        busy;
    logic [15:0] ovf;
    logic [1:0]  slot;

    zeroriscy_trace_ctrl_if bus ();

    zeroriscy_trace_ctrl #(.FIFO_DEPTH(DEPTH), .BUF_RECORDS(BUFR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trace_en_i     (en),
        .retire_valid_i (rv),
        .retire_pc_i    (pc),
        .retire_instr_i (instr),
        .retire_wdata_i (wd),
        .buf_base_i     (base),
        .bus            (bus.master),
        .busy_o         (busy),
        .overflow_cnt_o (ovf),
        .slot_o         (slot)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    rec_t        q[$];
    int          m_slot = 0;
    int          m_k = 0;
    int          m_ovf = 0;
    logic [31:0] m_cyc = 32'd0;
    bit          s_out = 1'b0;
    int          n_done = 0;
    logic [31:0] last_rec_addr = 32'd0;
    logic [31:0] wl_addr[$];
    logic [31:0] wl_data[$];
    int          gnt_mode = 0;
    int          hold_cnt = 0;
    bit          rv_hold = 1'b0;
    bit          stray = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: sampled mid-cycle, then advanced to the state after the next edge.
    always @(negedge clk) begin
        bit   full;
        rec_t r;
        if (!rst_n) begin
            q.delete();
            m_slot = 0; m_k = 0; m_ovf = 0; m_cyc = 32'd0; s_out = 1'b0;
            chk("rst_req", {31'd0, bus.data_req_o}, 32'd0);
        end else begin
            full = (q.size() == DEPTH);
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            chk("ovf", {16'd0, ovf}, 32'(m_ovf));
            chk("slot", {30'd0, slot}, 32'(m_slot));
            chk("we", {31'd0, bus.data_we_o}, {31'd0, bus.data_req_o});
            chk("be", {28'd0, bus.data_be_o}, {28'd0, {4{bus.data_req_o}}});
            if (bus.data_req_o) begin
                chk("req_legal", {31'd0, (q.size() != 0) && !s_out}, 32'd1);
                chk("addr", bus.data_addr_o, (base & 32'hFFFF_FFF0) + 32'(m_slot * 16) + 32'(m_k * 4));
                if (q.size() != 0) chk("wdata", bus.data_wdata_o, q[0][m_k]);
            end else begin
                chk("addr_idle", bus.data_addr_o, 32'd0);
                chk("wdata_idle", bus.data_wdata_o, 32'd0);
            end
            if (bus.data_rvalid_i && s_out) begin
                s_out = 1'b0;
                if (m_k == 3) begin
                    if (q.size() != 0) void'(q.pop_front());
                    m_slot = (m_slot + 1) % BUFR;
                    m_k    = 0;
                    n_done++;
                end else begin
                    m_k++;
                end
            end else if (bus.data_req_o && bus.data_gnt_i) begin
                s_out = 1'b1;
                wl_addr.push_back(bus.data_addr_o);
                wl_data.push_back(bus.data_wdata_o);
                if (m_k == 0) last_rec_addr = bus.data_addr_o;
            end
            if (en && rv) begin
                if (!full) begin
                    r = {wd, instr, pc, m_cyc};
                    q.push_back(r);
                end else if (m_ovf != 65535) begin
                    m_ovf++;
                end
            end
            m_cyc = m_cyc + 32'd1;
        end
    end

    // Memory slave: grant policy, optional hold-off on word 1, responses and stray responses.
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            bus.data_gnt_i    = 1'b0;
            bus.data_rvalid_i = 1'b0;
        end else begin
            if (hold_cnt > 0 && bus.data_req_o && bus.data_addr_o[3:0] == 4'h4) begin
                bus.data_gnt_i = 1'b0;
                hold_cnt--;
            end else begin
                case (gnt_mode)
                    0:       bus.data_gnt_i = 1'b1;
                    1:       bus.data_gnt_i = 1'b0;
                    default: bus.data_gnt_i = (($urandom % 3) != 0);
                endcase
            end
            if (s_out && !rv_hold)
                bus.data_rvalid_i = (gnt_mode == 2) ? (($urandom % 2) == 0) : 1'b1;
            else if (!s_out)
                bus.data_rvalid_i = stray || (gnt_mode == 2 && ($urandom % 8) == 0);
            else
                bus.data_rvalid_i = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int bound);
        int i;
        i = 0;
        while (busy && i < bound) begin
            step();
            i++;
        end
        chk({"drain_", tag}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_req(input string tag, input logic [3:0] low, input int bound);
        int i;
        i = 0;
        while (!(bus.data_req_o && bus.data_addr_o[3:0] == low) && i < bound) begin
            step();
            i++;
        end
        chk({"found_", tag}, {31'd0, bus.data_req_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] c0;
        logic [31:0] e[4];
        int          d0;
        int          cnt;

        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        base  = 32'h1000;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_req0", {31'd0, bus.data_req_o}, 32'd0);
        chk("rst_addr0", bus.data_addr_o, 32'd0);
        chk("rst_wdata0", bus.data_wdata_o, 32'd0);
        chk("rst_busy0", {31'd0, busy}, 32'd0);
        chk("rst_slot0", {30'd0, slot}, 32'd0);
        chk("rst_ovf0", {16'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        step();

        // Single record and two-cycle latency
        wl_addr.delete(); wl_data.delete();
        c0 = m_cyc;
        rv = 1'b1; pc = 32'h80; instr = 32'h0010_0093; wd = 32'd1;
        step();
        rv = 1'b0;
        chk("lat_push", {31'd0, bus.data_req_o}, 32'd0);
        step();
        chk("lat_req", {31'd0, bus.data_req_o}, 32'd1);
        drain("single", 50);
        e = '{c0, 32'h80, 32'h0010_0093, 32'd1};
        chk("single_n", 32'(wl_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wl_addr.size()) begin
                chk("single_addr", wl_addr[i], 32'h1000 + 32'(4 * i));
                chk("single_data", wl_data[i], e[i]);
            end
        end
        chk("single_slot", {30'd0, slot}, 32'd1);

        // Back-pressure on word 1
        do_reset();
        wl_addr.delete(); wl_data.delete();
        hold_cnt = 5;
        rv = 1'b1; pc = 32'h84; instr = $urandom; wd = $urandom;
        step();
        rv = 1'b0;
        wait_req("bp", 4'h4, 50);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req", {31'd0, bus.data_req_o}, 32'd1);
            chk("bp_addr", bus.data_addr_o, 32'h1004);
            chk("bp_wdata", bus.data_wdata_o, 32'h84);
            step();
        end
        drain("bp", 100);
        cnt = 0;
        foreach (wl_addr[i]) if (wl_addr[i] == 32'h1004) cnt++;
        chk("bp_nodup", 32'(cnt), 32'd1);
        chk("bp_n", 32'(wl_addr.size()), 32'd4);

        // Overflow with grant withheld
        do_reset();
        wl_addr.delete(); wl_data.delete();
        gnt_mode = 1;
        for (int i = 0; i < 6; i++) begin
            rv = 1'b1; pc = 32'h100 + 32'(4 * i); instr = $urandom; wd = $urandom;
            step();
        end
        rv = 1'b0;
        chk("ovf_cnt", {16'd0, ovf}, 32'd2);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        d0 = n_done;
        gnt_mode = 0;
        drain("ovf", 300);
        chk("ovf_done", 32'(n_done - d0), 32'd4);
        chk("ovf_n", 32'(wl_data.size()), 32'd16);
        for (int i = 0; i < 4; i++)
            if (4 * i + 1 < wl_data.size()) chk("ovf_order", wl_data[4 * i + 1], 32'h100 + 32'(4 * i));
        chk("ovf_hold", {16'd0, ovf}, 32'd2);

        // Ring wrap
        do_reset();
        base = 32'h2000;
        d0 = n_done;
        for (int r = 0; r < 5; r++) begin
            rv = 1'b1; pc = 32'h200 + 32'(r); instr = $urandom; wd = $urandom;
            step();
            rv = 1'b0;
            drain("wrap", 100);
        end
        chk("wrap_done", 32'(n_done - d0), 32'd5);
        chk("wrap_slot", {30'd0, slot}, 32'd1);
        chk("wrap_addr", last_rec_addr, 32'h2000);

        // Enable gating
        do_reset();
        base = 32'h1000;
        wl_addr.delete(); wl_data.delete();
        en = 1'b0; rv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("en_busy", {31'd0, busy}, 32'd0);
            chk("en_ovf", {16'd0, ovf}, 32'd0);
            chk("en_req", {31'd0, bus.data_req_o}, 32'd0);
        end
        gnt_mode = 1;
        en = 1'b1; pc = 32'h300;
        step();
        pc = 32'h304;
        step();
        en = 1'b0;
        chk("en_busy2", {31'd0, busy}, 32'd1);
        repeat (3) step();
        d0 = n_done;
        gnt_mode = 0;
        drain("en", 200);
        rv = 1'b0;
        chk("en_done", 32'(n_done - d0), 32'd2);
        chk("en_ovf2", {16'd0, ovf}, 32'd0);
        if (wl_data.size() >= 8) begin
            chk("en_rec0", wl_data[1], 32'h300);
            chk("en_rec1", wl_data[5], 32'h304);
        end else begin
            chk("en_n", 32'(wl_data.size()), 32'd8);
        end

        // Reset while waiting for the k=2 response
        do_reset();
        en = 1'b1;
        rv = 1'b1; pc = 32'h400; instr = $urandom; wd = $urandom;
        step();
        rv = 1'b0;
        wait_req("k2", 4'h8, 50);
        rv_hold = 1'b1;
        step();
        step();
        chk("k2_wait_req", {31'd0, bus.data_req_o}, 32'd0);
        chk("k2_wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_req", {31'd0, bus.data_req_o}, 32'd0);
        chk("ar_we", {31'd0, bus.data_we_o}, 32'd0);
        chk("ar_be", {28'd0, bus.data_be_o}, 32'd0);
        chk("ar_addr", bus.data_addr_o, 32'd0);
        chk("ar_wdata", bus.data_wdata_o, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_slot", {30'd0, slot}, 32'd0);
        chk("ar_ovf", {16'd0, ovf}, 32'd0);
        step();
        step();
        rst_n   = 1'b1;
        rv_hold = 1'b0;
        stray   = 1'b1;
        step();
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_slot", {30'd0, slot}, 32'd0);
            chk("stray_busy", {31'd0, busy}, 32'd0);
            chk("stray_req", {31'd0, bus.data_req_o}, 32'd0);
        end

        // Randomized traffic against the model
        do_reset();
        gnt_mode = 2;
        base = $urandom;
        for (int i = 0; i < 3000; i++) begin
            en    = (($urandom % 5) != 0);
            rv    = (($urandom % 3) == 0);
            pc    = $urandom;
            instr = $urandom;
            wd    = $urandom;
            step();
        end
        rv = 1'b0;
        drain("rand", 2000);
        chk("rand_req", {31'd0, bus.data_req_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
